// File: rtl/cipher_block_serializer.sv
// Fetches BLOCK_COUNT ciphertext blocks from the data memory read port and
// streams each one out MSB-first as OUT_WIDTH beats over a valid/ready handshake.
module cipher_block_serializer #(
  parameter int BLOCK_WIDTH = 128,
  parameter int OUT_WIDTH   = 8,
  parameter int BLOCK_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   read_enable,
  input  logic [BLOCK_WIDTH-1:0] read_data,
  input  logic                   data_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int BEATS  = BLOCK_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [15:0]       LAST_BLOCK = 16'(BLOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, REQ, SHIFT, DONE} state_t;

  state_t                 state;
  logic [BLOCK_WIDTH-1:0] shift_reg;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [15:0]            block_cnt;
  logic                   dr_q;
  logic                   rise;

  // Only a fresh rising edge counts, so a data_ready level left high from the
  // previous block cannot be mistaken for a new completion.
  assign rise     = data_ready & ~dr_q;
  assign out_data = shift_reg[BLOCK_WIDTH-1 -: OUT_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dr_q <= 1'b0;
    else     dr_q <= data_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      beat_cnt    <= '0;
      block_cnt   <= '0;
      read_enable <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          read_enable <= 1'b0;
          out_valid   <= 1'b0;
          done        <= 1'b0;
          busy        <= 1'b0;
          if (start) begin
            block_cnt   <= '0;
            busy        <= 1'b1;
            read_enable <= 1'b1;
            state       <= REQ;
          end
        end

        REQ: begin
          if (rise) begin
            shift_reg   <= read_data;
            beat_cnt    <= '0;
            read_enable <= 1'b0;
            out_valid   <= 1'b1;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (out_valid && out_ready) begin
            shift_reg <= shift_reg << OUT_WIDTH;
            // The beat counter stops on the last beat; the block decision is taken here.
            if (beat_cnt == LAST_BEAT) begin
              out_valid <= 1'b0;
              if (block_cnt == LAST_BLOCK) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                block_cnt   <= block_cnt + 16'd1;
                read_enable <= 1'b1;
                state       <= REQ;
              end
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_block_serializer.sv
// Scoreboard bench for cipher_block_serializer: a memory responder feeds random
// blocks, a monitor pops expected bytes per accepted beat and checks done/stalls.
module tb_cipher_block_serializer;

  localparam int BW    = 128;
  localparam int OW    = 8;
  localparam int BC    = 4;
  localparam int BEATS = BW / OW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          read_enable;
  logic [BW-1:0] read_data = '0;
  logic          data_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;

  cipher_block_serializer #(
    .BLOCK_WIDTH(BW),
    .OUT_WIDTH  (OW),
    .BLOCK_COUNT(BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .read_enable(read_enable),
    .read_data  (read_data),
    .data_ready (data_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } beat_t;

  beat_t         exp_q[$];
  logic [BW-1:0] blk_q[$];
  int            total = 0;
  int            bad = 0;
  int            ready_mode = 0;
  bit            sticky = 1'b0;
  int            beats_seen = 0;
  int            done_count = 0;
  int            re_count = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: owns out_ready, pops one expected byte per accepted beat.
  initial begin
    bit         exp_done;
    bit         hold;
    logic [7:0] held;
    int         cyc;
    beat_t      e;
    exp_done = 1'b0;
    hold     = 1'b0;
    held     = '0;
    cyc      = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_done  = 1'b0;
        hold      = 1'b0;
        out_ready = 1'b0;
        continue;
      end
      if (done || exp_done) begin
        checkOutput("done_pulse", 128'(done), 128'(exp_done));
        if (exp_done) done_count++;
      end
      exp_done = 1'b0;
      if (hold) begin
        checkOutput("stall_valid", 128'(out_valid), 128'(1));
        checkOutput("stall_data", 128'(out_data), 128'(held));
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      hold = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat", 128'(out_data), 128'(e.b));
          exp_done = e.last;
        end
        beats_seen++;
      end else if (out_valid) begin
        hold = 1'b1;
        held = out_data;
      end
    end
  end

  // Data memory model: answers each read request after a short latency with a
  // fresh data_ready rise; in sticky mode data_ready is left high afterwards.
  initial begin
    int            phase;
    int            wcnt;
    logic [BW-1:0] cur;
    phase = 0;
    wcnt  = 0;
    cur   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase      = 0;
        data_ready = 1'b0;
        continue;
      end
      case (phase)
        0: if (read_enable && blk_q.size() > 0) begin
             cur       = blk_q.pop_front();
             read_data = {$urandom, $urandom, $urandom, $urandom};
             wcnt      = sticky ? int'($urandom_range(1, 3)) : 2;
             phase     = 1;
           end
        1: begin
             wcnt--;
             if (wcnt <= 0) begin
               if (data_ready) begin
                 data_ready = 1'b0;
                 phase      = 2;
               end else begin
                 read_data  = cur;
                 data_ready = 1'b1;
                 phase      = 3;
               end
             end
           end
        2: begin
             read_data  = cur;
             data_ready = 1'b1;
             phase      = 3;
           end
        default: if (!read_enable) begin
             if (!sticky) data_ready = 1'b0;
             phase = 0;
           end
      endcase
    end
  end

  initial begin
    bit re_prev;
    re_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (read_enable && !re_prev) re_count++;
      re_prev = read_enable;
    end
  end

  task automatic loadBlocks(input int fixed_sel);
    logic [BW-1:0] blk;
    beat_t         e;
    for (int b = 0; b < BC; b++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      if (fixed_sel == 1 && b == 0) blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      if (fixed_sel == 2) blk = {32{4'(b + 1)}};
      blk_q.push_back(blk);
      for (int k = 0; k < BEATS; k++) begin
        e.b    = blk[BW-1-8*k -: 8];
        e.last = (b == BC - 1) && (k == BEATS - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input int rmode, input bit stk, input int fixed_sel, input int extra_start);
    int base_done;
    int base_re;
    int base_beats;
    bit pulsed;
    ready_mode = rmode;
    sticky     = stk;
    pulsed     = 1'b0;
    loadBlocks(fixed_sel);
    base_done  = done_count;
    base_re    = re_count;
    base_beats = beats_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 128'(busy), 128'(1));
    for (int budget = 0; budget < 3000 && done_count == base_done; budget++) begin
      @(negedge clk);
      if (extra_start >= 0 && !pulsed && beats_seen - base_beats >= extra_start) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_count == base_done) reportTimeout("done_wait");
    checkOutput("read_enable_count", 128'(re_count - base_re), 128'(BC));
    @(negedge clk);
    checkOutput("busy_after_done", 128'(busy), 128'(0));
    checkOutput("queue_empty", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    blk_q.delete();
  endtask

  task automatic resetMidStream();
    int base_beats;
    int budget;
    ready_mode = 0;
    sticky     = 1'b0;
    loadBlocks(0);
    base_beats = beats_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (budget = 0; budget < 1000 && beats_seen - base_beats < BEATS + 7; budget++) @(negedge clk);
    if (beats_seen - base_beats < BEATS + 7) reportTimeout("reach_beat7_block2");
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("async_rst_read_enable", 128'(read_enable), 128'(0));
    checkOutput("async_rst_busy", 128'(busy), 128'(0));
    checkOutput("async_rst_done", 128'(done), 128'(0));
    checkOutput("async_rst_out_data", 128'(out_data), 128'(0));
    @(negedge clk);
    exp_q.delete();
    blk_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_after_rst_busy", 128'(busy), 128'(0));
    checkOutput("idle_after_rst_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    checkOutput("reset_read_enable", 128'(read_enable), 128'(0));
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_out_data", 128'(out_data), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 1, -1);
    applyStimulus(1, 1'b0, 1, -1);
    applyStimulus(2, 1'b0, 2, -1);
    applyStimulus(0, 1'b1, 0, -1);
    applyStimulus(2, 1'b1, 0, -1);
    applyStimulus(0, 1'b0, 0, 20);
    resetMidStream();
    applyStimulus(0, 1'b0, 0, -1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0, -1);
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
